// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: display reads take priority over camera writes.
// Define FB_STARVE_GUARD_EN to let a starved writer steal one display slot.
module fb_port_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pix,
  output logic              o_pix_valid,
  output logic              o_miss,
  output logic              o_wr_err
);

  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int          CNT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, FWD} slot_t;

  slot_t             state;
  slot_t             nxt;
  logic              disp_req;
  logic              wr_oob;
  logic              accept;
  logic              force_wr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              rd_v2;
  logic              miss_v2;

  assign disp_req = (i_x < 10'(FB_W)) && (i_y < 10'(FB_H));
  assign rd_addr  = ADDR_W'(i_y) * ADDR_W'(FB_W) + ADDR_W'(i_x);
  assign wr_oob   = 32'(i_wr_addr) >= FB_SIZE;

`ifdef FB_STARVE_GUARD_EN
  assign force_wr = i_wr_valid && disp_req && (wait_cnt == CNT_W'(MAX_WAIT));
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    nxt = IDLE;
    if (force_wr)
      nxt = FWD;
    else if (disp_req)
      nxt = RD;
    else if (i_wr_valid)
      nxt = WR;
  end

  assign o_wr_ready = (nxt == WR) || (nxt == FWD);
  assign accept     = i_wr_valid && o_wr_ready;

  // Slot register drives the RAM port; results return two edges later and are
  // paired with the slot type via rd_v2/miss_v2.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_v2       <= 1'b0;
      miss_v2     <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_pix       <= '0;
      o_pix_valid <= 1'b0;
      o_miss      <= 1'b0;
      o_wr_err    <= 1'b0;
    end else begin
      state <= nxt;

      if (accept || !i_wr_valid)
        wait_cnt <= '0;
      else if (wait_cnt != CNT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + CNT_W'(1);

      o_mem_we <= accept && !wr_oob;
      o_wr_err <= accept && wr_oob;
      if (nxt == RD) begin
        o_mem_addr <= rd_addr;
      end else if (accept) begin
        o_mem_addr  <= i_wr_addr;
        o_mem_wdata <= i_wr_data;
      end

      rd_v2   <= (state == RD);
      miss_v2 <= (state == FWD);

      // A displaced pixel repeats the last output so the display keeps its cadence.
      o_pix_valid <= rd_v2 || miss_v2;
      if (rd_v2)
        o_pix <= i_mem_rdata;
      else if (!miss_v2)
        o_pix <= '0;
`ifdef FB_STARVE_GUARD_EN
      o_miss <= miss_v2;
`else
      o_miss <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter; follows FB_STARVE_GUARD_EN
// to pick the expected arbitration behaviour.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
`ifdef FB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [9:0]        ix;
  logic [9:0]        iy;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] pix;
  logic              pix_valid;
  logic              miss;
  logic              wr_err;

  int assertCount = 0;
  int failCount   = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_x         (ix),
    .i_y         (iy),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_pix       (pix),
    .o_pix_valid (pix_valid),
    .o_miss      (miss),
    .o_wr_err    (wr_err)
  );

  // Synchronous-read RAM stand-in: known pattern, with 0xABC planted at 325.
  function automatic logic [DATA_W-1:0] ramData(input logic [ADDR_W-1:0] a);
    if (a == 15'd325)
      return 12'hABC;
    return 12'h100 + a[11:0];
  endfunction

  always @(posedge clk) mem_rdata <= ramData(mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit wv, input int wa, input int wd);
    @(negedge clk);
    ix       = 10'(x);
    iy       = 10'(y);
    wr_valid = wv;
    wr_addr  = 15'(wa);
    wr_data  = 12'(wd);
    #1;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_addr"},  32'(mem_addr), 0);
    checkOutput({tag, "_we"},    32'(mem_we), 0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 0);
    checkOutput({tag, "_pix"},   32'(pix), 0);
    checkOutput({tag, "_valid"}, 32'(pix_valid), 0);
    checkOutput({tag, "_miss"},  32'(miss), 0);
    checkOutput({tag, "_err"},   32'(wr_err), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int        k;
    bit        fwd;
    bit        wv;
    logic [11:0] expPix;

    rstn = 1'b1; ix = 10'd200; iy = 10'd200;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #3 rstn = 1'b0;
    #1 checkZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Single display read at (5,2)
    applyStimulus(5, 2, 0, 0, 0);
    checkOutput("rd_ready", 32'(wr_ready), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("rd_addr", 32'(mem_addr), 325);
    checkOutput("rd_we", 32'(mem_we), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("rd_early_valid", 32'(pix_valid), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("rd_pix", 32'(pix), 32'h0ABC);
    checkOutput("rd_valid", 32'(pix_valid), 1);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("out_pix", 32'(pix), 0);
    checkOutput("out_valid", 32'(pix_valid), 0);

    // Write while the beam is outside the window
    applyStimulus(200, 0, 1, 100, 12'h123);
    checkOutput("wr_ready", 32'(wr_ready), 1);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("wr_we", 32'(mem_we), 1);
    checkOutput("wr_addr", 32'(mem_addr), 100);
    checkOutput("wr_wdata", 32'(mem_wdata), 32'h123);
    checkOutput("wr_noerr", 32'(wr_err), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("wr_we_end", 32'(mem_we), 0);

    // Out-of-range write is accepted and dropped
    applyStimulus(200, 0, 1, 19200, 12'h555);
    checkOutput("oob_ready", 32'(wr_ready), 1);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("oob_we", 32'(mem_we), 0);
    checkOutput("oob_err", 32'(wr_err), 1);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("oob_err_end", 32'(wr_err), 0);

    // 20 in-window cycles with a pending writer, then 3 idle cycles to drain
    for (int i = 0; i < 23; i++) begin
      wv = (i < 20) && (GUARD ? (i <= 8) : 1'b1);
      applyStimulus((i < 20) ? i : 200, 0, wv, 200, 12'h7E7);
      checkOutput("stream_ready", 32'(wr_ready), (GUARD && i == 8) ? 1 : 0);
      if (i >= 1)
        checkOutput("stream_we", 32'(mem_we), (GUARD && i == 9) ? 1 : 0);
      if (i >= 3) begin
        k      = i - 3;
        fwd    = GUARD && (k == 8);
        expPix = fwd ? 12'h107 : 12'(12'h100 + k);
        checkOutput("stream_pix", 32'(pix), 32'(expPix));
        checkOutput("stream_valid", 32'(pix_valid), 1);
        checkOutput("stream_miss", 32'(miss), 32'(fwd));
        if (miss)
          missCount++;
      end
    end
    checkOutput("miss_count", 32'(missCount), GUARD ? 1 : 0);

    // The wait counter restarts from zero for the next starved write
    for (int j = 0; j < 10; j++) begin
      applyStimulus(j, 1, j <= 8, 300, 12'h111);
      checkOutput("restart_ready", 32'(wr_ready), (GUARD && j == 8) ? 1 : 0);
    end

    // Reset with two reads in flight
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0);
    @(negedge clk);
    ix = 10'd200;
    rstn = 1'b0;
    #1 checkZero("midreset");
    checkOutput("midreset_ready", 32'(wr_ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    ix   = 10'd3;
    iy   = 10'd1;
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("resume_addr", 32'(mem_addr), 163);
    checkOutput("discard_valid_a", 32'(pix_valid), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("discard_valid_b", 32'(pix_valid), 0);
    applyStimulus(200, 0, 0, 0, 0);
    checkOutput("resume_pix", 32'(pix), 32'h1A3);
    checkOutput("resume_valid", 32'(pix_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter FB_W, default 160, frame buffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 120, frame buffer height in lines.
REQ-003 SHALL have parameter ADDR_W, default 15, memory word address width.
REQ-004 SHALL have parameter DATA_W, default 12, pixel width (RGB444).
REQ-005 SHALL have parameter MAX_WAIT, default 8, writer starvation limit in cycles.
REQ-006 SHALL have port i_clk, input, 1, the single pixel clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports i_x and i_y, input, 10 each, display timing counters.
REQ-009 SHALL have ports i_wr_valid (input, 1), o_wr_ready (output, 1), i_wr_addr (input, ADDR_W) and i_wr_data (input, DATA_W) forming the camera write handshake.
REQ-010 SHALL have ports o_mem_addr (output, ADDR_W), o_mem_we (output, 1), o_mem_wdata (output, DATA_W) and i_mem_rdata (input, DATA_W) forming the single-port RAM port.
REQ-011 SHALL have ports o_pix (output, DATA_W), o_pix_valid (output, 1), o_miss (output, 1) and o_wr_err (output, 1).

Function
REQ-012 SHALL define a display request in a cycle when i_x < FB_W and i_y < FB_H.
REQ-013 SHALL compute the read address as i_y*FB_W + i_x, truncated to ADDR_W bits, with no overflow for legal coordinates.
REQ-014 SHALL register one slot decision per cycle as a state: IDLE (no request), RD (display read), WR (write), or FWD (forced write).
REQ-015 SHALL select RD whenever a display request exists and no forced write is due.
REQ-016 SHALL select WR when i_wr_valid is high and no display request exists.
REQ-017 SHALL drive o_wr_ready combinationally high exactly in cycles whose next state is WR or FWD; a write is accepted when i_wr_valid and o_wr_ready are both high.
REQ-018 SHALL register o_mem_addr, o_mem_we and o_mem_wdata one cycle after the slot decision; o_mem_we is 1 only for accepted writes.
REQ-019 SHALL treat i_mem_rdata as valid one cycle after an RD slot was presented on the memory port.
REQ-020 SHALL register o_pix and o_pix_valid 3 cycles after the coordinate cycle that produced the RD slot.
REQ-021 SHALL hold o_pix at 0 with o_pix_valid low for coordinates outside the window.
REQ-022 SHALL accept a write with i_wr_addr >= FB_W*FB_H and drop it (o_mem_we=0), pulsing o_wr_err high for 1 cycle aligned with the memory-port cycle.
REQ-023 SHALL keep a saturating wait counter that increments in each cycle with i_wr_valid high and o_wr_ready low, and clears on write acceptance or when i_wr_valid is low.
REQ-024 SHALL maintain pipeline valid bits so that each memory result is paired with the slot type that issued it.

Reset
REQ-025 SHALL, while i_rstn is low, asynchronously force state IDLE, wait counter 0, pipeline valid bits 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0, o_pix 0, o_pix_valid 0, o_miss 0 and o_wr_err 0.
REQ-026 SHALL discard in-flight reads and writes on reset mid-operation and emit no o_pix_valid for them after reset release.
REQ-027 SHALL resume arbitration on the first rising edge after i_rstn deasserts.

Configuration
REQ-028 SHALL implement the starvation guard only when macro FB_STARVE_GUARD_EN is defined.
REQ-029 SHALL, with FB_STARVE_GUARD_EN defined, select FWD instead of RD when the wait counter equals MAX_WAIT and i_wr_valid is high; the displaced pixel slot outputs the previous o_pix with o_pix_valid high and o_miss high for 1 cycle, at the same 3-cycle latency.
REQ-030 SHALL, without FB_STARVE_GUARD_EN, use strict display priority, never enter FWD, and hold o_miss constantly 0.

Verification
REQ-031 SHALL verify: i_x=5, i_y=2, i_mem_rdata returns 0xABC -> o_mem_addr=325 and we=0, then o_pix=0xABC with o_pix_valid high 3 cycles after the coordinate.
REQ-032 SHALL verify: i_x=200 (outside window) with i_wr_valid high, addr 100, data 0x123 -> o_wr_ready high, o_mem_we=1, o_mem_addr=100, o_mem_wdata=0x123.
REQ-033 SHALL verify: write to addr 19200 -> accepted, o_mem_we=0, one o_wr_err pulse.
REQ-034 SHALL verify, with FB_STARVE_GUARD_EN defined: i_wr_valid held high during 20 consecutive in-window cycles -> write granted after 8 wait cycles, one o_miss pulse, o_pix repeats the prior value, counter clears.
REQ-035 SHALL verify, without FB_STARVE_GUARD_EN: the same stimulus -> o_wr_ready stays low for all 20 cycles and o_miss stays 0.
REQ-036 SHALL verify: i_rstn pulsed low with 2 reads in flight -> all outputs are 0 immediately, and no o_pix_valid is produced for the discarded reads.
